data_ram_ctrl: RTL and testbench

Parametrised data memory for the single-cycle core's load/store path. It replaces the bare byte-masked word RAM with a request/response handshake, configurable wait states, and an internal RV32 load/store size decoder. Byte lanes are derived internally and loads are sign- or zero-extended. Misaligned and out-of-range accesses are flagged. The block sits between the core's memory stage and the word-organised storage array.

---
 rtl/data_ram_ctrl_if.sv | 24 ++
 rtl/data_ram_ctrl.sv | 162 ++++++++++++++++
 tb/tb_data_ram_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_ctrl_if.sv
// Load/store request/response bundle between the core memory stage and data_ram_ctrl.
interface data_ram_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_ram_ctrl.sv
// Handshaked RV32 data memory with wait states, byte-lane store decode and extending loads.
// Define RAM_ERR_EN to flag misaligned/out-of-range/illegal-size accesses on rsp_err.
module data_ram_ctrl #(
  parameter int ADDR_W      = 7,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  data_ram_ctrl_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
`ifdef RAM_ERR_EN
  localparam int AQ_W = 32;
`else
  localparam int AQ_W = ADDR_W + 2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [AQ_W-1:0]   addr_q;
  logic [31:0]       wdata_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  logic [31:0]       mem [DEPTH];

  logic [1:0]        size_eff, off;
  logic [ADDR_W-1:0] widx;
  logic [3:0]        lane_mask;
  logic [31:0]       lane_data, shifted, load_data;
  logic              acc_err;

  assign bus.req_ready = (state_q == S_IDLE) && rst_n;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.req_valid) state_d = (WS != 4'd0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt_q <= 4'd1) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   if (bus.rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Without error checking, illegal size acts as word and misaligned offsets are forced aligned.
  always_comb begin
    size_eff = size_q;
`ifndef RAM_ERR_EN
    if (size_q == 2'b11) size_eff = 2'b10;
`endif
    off = addr_q[1:0];
    if (size_eff == 2'b01) off[0] = 1'b0;
    if (size_eff[1])       off    = 2'b00;
    widx = addr_q[ADDR_W+1:2];
  end

  always_comb begin
`ifdef RAM_ERR_EN
    acc_err = (size_q == 2'b11)
           || (size_q == 2'b01 && addr_q[0])
           || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
           || ((addr_q >> (ADDR_W + 2)) != '0);
`else
    acc_err = 1'b0;
`endif
  end

  always_comb begin
    lane_mask = 4'b1111;
    lane_data = wdata_q;
    unique case (size_eff)
      2'b00: begin
        lane_mask = 4'b0001 << off;
        lane_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_mask = 4'b0011 << off;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    shifted   = mem[widx] >> {off, 3'b000};
    load_data = shifted;
    unique case (size_eff)
      2'b00:   load_data = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Array has no reset; an async reset moves state out of ACCESS, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && we_q && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lane_mask[b]) mem[widx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr[AQ_W-1:0];
            wdata_q <= bus.req_wdata;
            cnt_q   <= WS;
          end
        end
        S_WAIT: cnt_q <= cnt_q - 4'd1;
        S_ACCESS: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= acc_err;
          rsp_rdata_q <= (we_q || acc_err) ? '0 : load_data;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl: two instances (0 and 3 wait states) checked against a byte-level model.
module tb_data_ram_ctrl;
  localparam int AW    = 7;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_ram_ctrl_if if0();
  data_ram_ctrl_if if3();

  data_ram_ctrl #(.ADDR_W(AW), .WAIT_STATES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  data_ram_ctrl #(.ADDR_W(AW), .WAIT_STATES(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int total = 0;
  int bad   = 0;

  logic [7:0]  mref [2][DEPTH*4];
  bit          pend [2];
  logic [31:0] exp_rd [2];
  bit          exp_er [2];

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic o_valid(input int d);
    return (d == 0) ? if0.rsp_valid : if3.rsp_valid;
  endfunction
  function automatic logic o_rdy(input int d);
    return (d == 0) ? if0.req_ready : if3.req_ready;
  endfunction
  function automatic logic [31:0] o_rdata(input int d);
    return (d == 0) ? if0.rsp_rdata : if3.rsp_rdata;
  endfunction
  function automatic logic o_err(input int d);
    return (d == 0) ? if0.rsp_err : if3.rsp_err;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic drive(input int d, input bit v, input bit we, input logic [1:0] sz,
                       input bit un, input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      if0.req_valid = v; if0.req_we = we; if0.req_size = sz;
      if0.req_unsigned = un; if0.req_addr = a; if0.req_wdata = wd;
    end else begin
      if3.req_valid = v; if3.req_we = we; if3.req_size = sz;
      if3.req_unsigned = un; if3.req_addr = a; if3.req_wdata = wd;
    end
  endtask

  task automatic set_rdy(input int d, input bit r);
    if (d == 0) if0.rsp_ready = r;
    else        if3.rsp_ready = r;
  endtask

  // Byte-addressed little-endian memory: an access touches n consecutive bytes.
  function automatic void model(input int d, input bit we, input logic [1:0] sz, input bit un,
                                input logic [31:0] a, input logic [31:0] wd, input bit commit,
                                output logic [31:0] rd, output bit er);
    int n;
    int ea;
    logic [31:0] v;
    n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    rd = '0;
    er = 1'b0;
`ifdef RAM_ERR_EN
    er = (sz == 2'b11) || ((a % 32'(n)) != 0) || (a >= 32'(4 * DEPTH));
    ea = int'(a % 32'(4 * DEPTH));
`else
    ea = int'((a & ~32'(n - 1)) % 32'(4 * DEPTH));
`endif
    if (er) return;
    if (we) begin
      if (commit) for (int i = 0; i < n; i++) mref[d][ea + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mref[d][ea + i];
      if (n < 4 && !un && v[8*n - 1]) for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
      rd = v;
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (pend[d]) begin
          if (o_valid(d) === 1'b1) begin
            chk("cmp_rdata", o_rdata(d), exp_rd[d]);
            chk("cmp_err", 32'(o_err(d)), 32'(exp_er[d]));
            chk("cmp_busy_ready", 32'(o_rdy(d)), 32'd0);
          end
        end else begin
          chk("cmp_idle_valid", 32'(o_valid(d)), 32'd0);
        end
      end
    end
  end

  task automatic start(input int d, input bit we, input logic [1:0] sz, input bit un,
                       input logic [31:0] a, input logic [31:0] wd, input bit commit);
    int n;
    logic [31:0] r;
    bit e;
    n = 0;
    @(negedge clk);
    while (o_rdy(d) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(o_rdy(d)), 32'd1);
    drive(d, 1'b1, we, sz, un, a, wd);
    @(posedge clk);
    #1;
    drive(d, 1'b0, ~we, ~sz, ~un, ~a, ~wd);
    model(d, we, sz, un, a, wd, commit, r, e);
    exp_rd[d] = r;
    exp_er[d] = e;
    pend[d]   = 1'b1;
  endtask

  task automatic finish(input int d, input int hold, output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    while (o_valid(d) !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(ws(d) + 1));
    rd = o_rdata(d);
    er = o_err(d);
    repeat (hold) @(negedge clk);
    @(negedge clk);
    set_rdy(d, 1'b1);
    @(posedge clk);
    #1;
    set_rdy(d, 1'b0);
    pend[d] = 1'b0;
    chk("rsp_valid_drop", 32'(o_valid(d)), 32'd0);
  endtask

  task automatic txn(input int d, input bit we, input logic [1:0] sz, input bit un,
                     input logic [31:0] a, input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er);
    start(d, we, sz, un, a, wd, 1'b1);
    finish(d, hold, rd, er);
  endtask

  task automatic st(input int d, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    logic er;
    txn(d, 1'b1, sz, 1'b0, a, wd, 0, rd, er);
  endtask

  task automatic ld(input string nm, input int d, input logic [1:0] sz, input bit un,
                    input logic [31:0] a, input logic [31:0] want, input bit want_err, input int hold);
    logic [31:0] rd;
    logic er;
    txn(d, 1'b0, sz, un, a, '0, hold, rd, er);
    chk(nm, rd, want);
    chk({nm, "_err"}, 32'(er), 32'(want_err));
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int n;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    set_rdy(0, 1'b0);
    set_rdy(1, 1'b0);

    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(o_rdy(d)), 32'd0);
      chk("rst_rsp_valid", 32'(o_valid(d)), 32'd0);
      chk("rst_rsp_rdata", o_rdata(d), 32'd0);
      chk("rst_rsp_err", 32'(o_err(d)), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready0", 32'(o_rdy(0)), 32'd1);
    chk("post_rst_ready3", 32'(o_rdy(1)), 32'd1);

    // Zero wait states: word, byte and half accesses.
    st(0, 2'b10, 32'h10, 32'hDEADBEEF);
    ld("ld_w10", 0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 0);
    st(0, 2'b00, 32'h13, 32'h1234565A);
    ld("ld_b13s", 0, 2'b00, 1'b0, 32'h13, 32'h0000005A, 1'b0, 0);
    ld("ld_b12s", 0, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAD, 1'b0, 0);
    ld("ld_h12u", 0, 2'b01, 1'b1, 32'h12, 32'h00005AAD, 1'b0, 0);
    ld("ld_b12u", 0, 2'b00, 1'b1, 32'h12, 32'h000000AD, 1'b0, 0);
    ld("ld_w10b", 0, 2'b10, 1'b1, 32'h10, 32'h5AADBEEF, 1'b0, 0);
    st(0, 2'b10, 32'h14, 32'h00000000);
    st(0, 2'b01, 32'h16, 32'hABCD8001);
    ld("ld_h16s", 0, 2'b01, 1'b0, 32'h16, 32'hFFFF8001, 1'b0, 0);
    ld("ld_w14", 0, 2'b10, 1'b0, 32'h14, 32'h80010000, 1'b0, 0);

    // Three wait states with a back-pressured response.
    st(1, 2'b10, 32'h20, 32'h11111111);
    ld("ld_w20_hold", 1, 2'b10, 1'b0, 32'h20, 32'h11111111, 1'b0, 5);

`ifdef RAM_ERR_EN
    txn(0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h99999999, 0, rd, er);
    chk("err_st_mis", 32'(er), 32'd1);
    chk("err_st_rdata", rd, 32'd0);
    ld("err_w10_keep", 0, 2'b10, 1'b0, 32'h10, 32'h5AADBEEF, 1'b0, 0);
    ld("err_oor", 0, 2'b10, 1'b0, 32'(4 << AW), 32'd0, 1'b1, 0);
    ld("err_sz3", 0, 2'b11, 1'b0, 32'h10, 32'd0, 1'b1, 0);
    ld("err_h11", 0, 2'b01, 1'b0, 32'h11, 32'd0, 1'b1, 0);
`else
    st(0, 2'b10, 32'h23, 32'hCAFEF00D);
    ld("wrap_w20", 0, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0, 0);
    ld("wrap_hi", 0, 2'b10, 1'b0, 32'h20 + 32'(4 << AW), 32'hCAFEF00D, 1'b0, 0);
    ld("wrap_sz3", 0, 2'b11, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0, 0);
    ld("wrap_h21u", 0, 2'b01, 1'b1, 32'h21, 32'h0000F00D, 1'b0, 0);
`endif

    // Reset during WAIT discards the pending store.
    start(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h22222222, 1'b0);
    @(posedge clk);
    #1;
    pend[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(o_valid(1)), 32'd0);
    chk("abort_rdata", o_rdata(1), 32'd0);
    chk("abort_err", 32'(o_err(1)), 32'd0);
    chk("abort_ready", 32'(o_rdy(1)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ld("ld_w20_after_abort", 1, 2'b10, 1'b0, 32'h20, 32'h11111111, 1'b0, 0);

    // Reset during RESP drops the response asynchronously.
    start(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1);
    n = 0;
    while (o_valid(1) !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drop_valid_before", 32'(o_valid(1)), 32'd1);
    @(negedge clk);
    #2;
    pend[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("drop_valid", 32'(o_valid(1)), 32'd0);
    chk("drop_rdata", o_rdata(1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("drop_ready_after", 32'(o_rdy(1)), 32'd1);
    ld("ld_w20_final", 1, 2'b10, 1'b0, 32'h20, 32'h11111111, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
